// File: rtl/timer_arb_pkg.sv
// -----------------------------------------------------------------------------
// timer_arb_pkg
// Shared types and configuration for the two-master machine-timer arbiter.
//   timer_req_type : captured request (valid doubles as the pending flag)
//   timer_rsp_type : completion routed back to the granted master
//   arb_state_type : arbiter FSM states
//   pick_grant     : round-robin winner selection
// Optional feature macro used by the arbiter: TIMER_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package timer_arb_pkg;

    // Default WAIT-cycle budget before an unanswered access is force-completed.
    localparam int TIMER_ARB_TIMEOUT = 15;
    // Width of the timeout counter; TIMER_ARB_TIMEOUT must stay below 2**TIMER_ARB_TO_W.
    localparam int TIMER_ARB_TO_W    = 4;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } timer_req_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        err;
    } timer_rsp_type;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_type;

    // Returns the master index to serve: the only pending one, or prio when both wait.
    function automatic logic pick_grant(input logic pend0, input logic pend1, input logic prio);
        logic sel;
        if (pend0 && pend1) begin
            sel = prio;
        end else if (pend1) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_arb_slot.sv
// -----------------------------------------------------------------------------
// timer_arb_slot
// Per-master request capture register with pending flag.
// A one-cycle valid strobe is latched only while nothing is pending; a strobe
// arriving while pending is a protocol error and is dropped without touching
// the latched fields. The arbiter clears the pending flag on completion.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid/instr/addr/wdata/wstrb  master request strobe and fields
//   clear                     completion of this slot's transaction
//   req                       latched request; req.valid is the pending flag
// -----------------------------------------------------------------------------
module timer_arb_slot
    import timer_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          instr,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          clear,
    output timer_req_type req
);

    timer_req_type req_r;

    // Capture a new request when idle, drop it while pending, release on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r <= '0;
        end else if (clear) begin
            req_r.valid <= 1'b0;
        end else if (valid && !req_r.valid) begin
            req_r.valid <= 1'b1;
            req_r.instr <= instr;
            req_r.addr  <= addr;
            req_r.wdata <= wdata;
            req_r.wstrb <= wstrb;
        end else begin
            req_r <= req_r;
        end
    end

    assign req = req_r;

endmodule

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
// Shares the machine-timer slave between a fetch master (m0) and a data
// master (m1). Requests are captured per master, granted one at a time in
// round-robin order, issued to the timer as a one-cycle s_valid, and the
// timer's response is returned to the granted master only.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mN_valid/instr/addr/wdata/wstrb  master request (N = 0, 1)
//   mN_rdata/ready/err             master completion (err = timeout)
//   s_valid/instr/addr/wdata/wstrb request to the timer (fields held in WAIT)
//   s_rdata/s_ready                timer response
// Configuration:
//   TIMER_ARB_TIMEOUT_EN  when defined, an access left unanswered for TIMEOUT
//                         WAIT cycles completes with err=1 and rdata=0; the
//                         timer never acknowledges writes to its count
//                         registers. When undefined, WAIT holds until s_ready
//                         and mN_err is constant 0.
// -----------------------------------------------------------------------------
module timer_arbiter
    import timer_arb_pkg::*;
`ifdef TIMER_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = TIMER_ARB_TIMEOUT,
    parameter int TO_W    = TIMER_ARB_TO_W
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    timer_req_type req0_s;
    timer_req_type req1_s;
    timer_rsp_type rsp_s;
    arb_state_type state_r;
    logic          gnt_r;
    logic          prio_r;
    logic          any_s;
    logic          sel_s;
    logic          clear0_s;
    logic          clear1_s;
`ifdef TIMER_ARB_TIMEOUT_EN
    logic [TO_W-1:0] cnt_r;
    logic            expire_s;
`endif

    timer_arb_slot u_slot0 (
        .clk   (clk),
        .rst   (rst),
        .valid (m0_valid),
        .instr (m0_instr),
        .addr  (m0_addr),
        .wdata (m0_wdata),
        .wstrb (m0_wstrb),
        .clear (clear0_s),
        .req   (req0_s)
    );

    timer_arb_slot u_slot1 (
        .clk   (clk),
        .rst   (rst),
        .valid (m1_valid),
        .instr (m1_instr),
        .addr  (m1_addr),
        .wdata (m1_wdata),
        .wstrb (m1_wstrb),
        .clear (clear1_s),
        .req   (req1_s)
    );

    // Grant selection among pending slots.
    always_comb begin
        any_s = req0_s.valid | req1_s.valid;
        sel_s = pick_grant(req0_s.valid, req1_s.valid, prio_r);
    end

`ifdef TIMER_ARB_TIMEOUT_EN
    // Expiry on the last budgeted WAIT cycle, so completion lands TIMEOUT cycles after s_valid.
    always_comb begin
        expire_s = (cnt_r == TO_W'(TIMEOUT - 1));
    end
`endif

    // Completion of the outstanding access; a real s_ready beats a coincident expiry.
    always_comb begin
        rsp_s = '0;
        if (state_r == WAIT && s_ready) begin
            rsp_s.rdata = s_rdata;
            rsp_s.ready = 1'b1;
            rsp_s.err   = 1'b0;
`ifdef TIMER_ARB_TIMEOUT_EN
        end else if (state_r == WAIT && expire_s) begin
            rsp_s.rdata = 32'h0000_0000;
            rsp_s.ready = 1'b1;
            rsp_s.err   = 1'b1;
`endif
        end else begin
            rsp_s = '0;
        end
        clear0_s = rsp_s.ready & ~gnt_r;
        clear1_s = rsp_s.ready &  gnt_r;
    end

    // Arbitration FSM, slave request issue and response routing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_r    <= 1'b0;
            prio_r   <= 1'b0;
            s_valid  <= 1'b0;
            s_instr  <= 1'b0;
            s_addr   <= 32'h0000_0000;
            s_wdata  <= 32'h0000_0000;
            s_wstrb  <= 4'h0;
            m0_rdata <= 32'h0000_0000;
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_rdata <= 32'h0000_0000;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            s_valid  <= 1'b0;
            m0_ready <= 1'b0;
            m0_err   <= 1'b0;
            m1_ready <= 1'b0;
            m1_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    // s_ready seen here is spurious and deliberately ignored.
                    if (any_s) begin
                        s_valid <= 1'b1;
                        s_instr <= sel_s ? req1_s.instr : req0_s.instr;
                        s_addr  <= sel_s ? req1_s.addr  : req0_s.addr;
                        s_wdata <= sel_s ? req1_s.wdata : req0_s.wdata;
                        s_wstrb <= sel_s ? req1_s.wstrb : req0_s.wstrb;
                        gnt_r   <= sel_s;
                        prio_r  <= ~sel_s;
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (rsp_s.ready) begin
                        if (gnt_r) begin
                            m1_rdata <= rsp_s.rdata;
                            m1_ready <= 1'b1;
                            m1_err   <= rsp_s.err;
                        end else begin
                            m0_rdata <= rsp_s.rdata;
                            m0_ready <= 1'b1;
                            m0_err   <= rsp_s.err;
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef TIMER_ARB_TIMEOUT_EN
    // WAIT-cycle counter, held at zero outside WAIT so every grant starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r == WAIT && !rsp_s.ready) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end
`endif

endmodule
